i2c_target: RTL and testbench

I2C target (responder) for the audio shield. It answers the shield's existing 100 kHz I2C initiator, or an off-board host, at a fixed 7-bit address and bridges transfers onto a simple byte-wide register port. Writes use the form `S addr+W ptr data… P`. Reads use the form `S addr+W ptr Sr addr+R data… P`. The register pointer auto-increments. SDA is driven open-drain by the top level.

---
 rtl/i2c_pkg.sv | 28 ++
 rtl/i2c_target_if.sv | 26 ++
 rtl/i2c_sync_edge.sv | 35 +++
 rtl/i2c_target.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_target.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// acknowledge levels and the position of the read/write flag in the address byte.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    WAIT_P    = 4'd9
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // The LSB of the address byte selects read (1) or write (0).
  localparam int RW_BIT = 0;

  function automatic logic addrMatch(input logic [7:0] addrByte, input logic [6:0] devAddr);
    return addrByte[7:1] == devAddr;
  endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Pad-side bus pins and the byte-wide register port of the I2C target.
interface i2c_target_if;

  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [3:0] i2c_state;

  // The target owns the register port; the master side drives pads and read data.
  modport slave (
    input  scl_i, sda_i, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_we, reg_rd, busy, i2c_state
  );

  modport master (
    output scl_i, sda_i, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_we, reg_rd, busy, i2c_state
  );

endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for an asynchronous pad input, followed by a
// rise/fall detector on the synchronised level.
module i2c_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to the idle bus level so that leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target at a fixed 7-bit address bridging pointer-addressed byte
// writes and reads onto a simple register port; SDA is open-drain via sda_oe.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h38
) (
  input logic         clk,
  input logic         reset,
  i2c_target_if.slave bus
);

  logic sclLvl, sclRise, sclFall;
  logic sdaLvl, sdaRise, sdaFall;

  i2c_sync_edge #(.RESET_VAL(1'b1)) uSclSync (
    .clk     (clk),
    .reset   (reset),
    .async_i (bus.scl_i),
    .level_o (sclLvl),
    .rise_o  (sclRise),
    .fall_o  (sclFall)
  );

  i2c_sync_edge #(.RESET_VAL(1'b1)) uSdaSync (
    .clk     (clk),
    .reset   (reset),
    .async_i (bus.sda_i),
    .level_o (sdaLvl),
    .rise_o  (sdaRise),
    .fall_o  (sdaFall)
  );

  i2c_state_t state_q;
  logic [3:0] bitCnt_q;
  logic [7:0] shift_q;
  logic [7:0] ptr_q;
  logic [7:0] wdata_q;
  logic       we_q;
  logic       rd_q;
  logic       loadPend_q;
  logic       rw_q;
  logic       masterNack_q;
  logic       sdaOe_q;
  logic       busy_q;

  logic       startDet, stopDet;
  logic       byteDone, byteEnd, rxShift;
  logic [7:0] shift_d;
  logic [7:0] ptr_d;

  assign startDet = sdaFall & sclLvl;
  assign stopDet  = sdaRise & sclLvl;
  assign shift_d  = {shift_q[6:0], sdaLvl};
  assign ptr_d    = ptr_q + 8'd1;
  assign rxShift  = sclRise && (bitCnt_q < 4'd8);
  // byteDone marks the SCL rise of bit 8; byteEnd the SCL fall that follows it.
  assign byteDone = sclRise && (bitCnt_q == 4'd7);
  assign byteEnd  = sclFall && (bitCnt_q == 4'd8);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bitCnt_q     <= 4'd0;
      shift_q      <= 8'h00;
      ptr_q        <= 8'h00;
      wdata_q      <= 8'h00;
      we_q         <= 1'b0;
      rd_q         <= 1'b0;
      loadPend_q   <= 1'b0;
      rw_q         <= 1'b0;
      masterNack_q <= 1'b0;
      sdaOe_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      we_q       <= 1'b0;
      rd_q       <= 1'b0;
      loadPend_q <= 1'b0;

      // A completed write byte always advances the pointer, even if STOP follows.
      if (we_q) begin
        ptr_q <= ptr_d;
      end

      if (loadPend_q && !stopDet && !startDet) begin
        shift_q <= bus.reg_rdata;
        ptr_q   <= ptr_d;
        sdaOe_q <= ~bus.reg_rdata[7];
      end

      if (stopDet) begin
        state_q  <= IDLE;
        bitCnt_q <= 4'd0;
        sdaOe_q  <= 1'b0;
        busy_q   <= 1'b0;
      end else if (startDet) begin
        state_q  <= ADDR;
        bitCnt_q <= 4'd0;
        sdaOe_q  <= 1'b0;
        busy_q   <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
          end

          ADDR: begin
            if (rxShift) begin
              shift_q  <= shift_d;
              bitCnt_q <= bitCnt_q + 4'd1;
            end
            if (byteEnd) begin
              bitCnt_q <= 4'd0;
              if (addrMatch(shift_q, DEV_ADDR)) begin
                rw_q    <= shift_q[RW_BIT];
                sdaOe_q <= ~I2C_ACK;
                state_q <= ADDR_ACK;
              end else begin
                state_q <= WAIT_P;
              end
            end
          end

          ADDR_ACK: begin
            if (sclFall) begin
              sdaOe_q  <= 1'b0;
              bitCnt_q <= 4'd0;
              if (rw_q) begin
                rd_q       <= 1'b1;
                loadPend_q <= 1'b1;
                state_q    <= RDATA;
              end else begin
                state_q <= PTR;
              end
            end
          end

          PTR: begin
            if (rxShift) begin
              shift_q  <= shift_d;
              bitCnt_q <= bitCnt_q + 4'd1;
            end
            if (byteDone) begin
              ptr_q <= shift_d;
            end
            if (byteEnd) begin
              bitCnt_q <= 4'd0;
              sdaOe_q  <= ~I2C_ACK;
              state_q  <= PTR_ACK;
            end
          end

          PTR_ACK, WDATA_ACK: begin
            if (sclFall) begin
              sdaOe_q  <= 1'b0;
              bitCnt_q <= 4'd0;
              state_q  <= WDATA;
            end
          end

          WDATA: begin
            if (rxShift) begin
              shift_q  <= shift_d;
              bitCnt_q <= bitCnt_q + 4'd1;
            end
            if (byteDone) begin
              wdata_q <= shift_d;
              we_q    <= 1'b1;
            end
            if (byteEnd) begin
              bitCnt_q <= 4'd0;
              sdaOe_q  <= ~I2C_ACK;
              state_q  <= WDATA_ACK;
            end
          end

          // bitCnt counts SCL falls; bit 7 is already on the wire after the load.
          RDATA: begin
            if (sclFall) begin
              if (bitCnt_q == 4'd7) begin
                bitCnt_q <= 4'd0;
                sdaOe_q  <= 1'b0;
                state_q  <= RDATA_ACK;
              end else begin
                bitCnt_q <= bitCnt_q + 4'd1;
                shift_q  <= {shift_q[6:0], 1'b0};
                sdaOe_q  <= ~shift_q[6];
              end
            end
          end

          RDATA_ACK: begin
            if (sclRise) begin
              masterNack_q <= sdaLvl;
            end
            if (sclFall) begin
              if (masterNack_q == I2C_NACK) begin
                state_q <= WAIT_P;
              end else begin
                rd_q       <= 1'b1;
                loadPend_q <= 1'b1;
                state_q    <= RDATA;
              end
            end
          end

          WAIT_P: begin
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.sda_oe    = sdaOe_q;
  assign bus.reg_addr  = ptr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_rd    = rd_q;
  assign bus.busy      = busy_q;
  assign bus.i2c_state = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C master on an open-drain bus, a
// register-file peripheral, and a memory/pointer reference model of the target.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 25;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic sclDrv = 1'b1;
  logic sdaDrv = 1'b1;

  i2c_target_if bus();

  i2c_target #(.DEV_ADDR(7'h38)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  logic [7:0] regFile [256] = '{default: 8'h00};

  assign bus.scl_i     = sclDrv;
  assign bus.sda_i     = sdaDrv & ~bus.sda_oe;
  assign bus.reg_rdata = regFile[bus.reg_addr];

  logic [15:0] weLog [$];
  logic [7:0]  rdLog [$];
  int          oeCycles   = 0;
  int          busyCycles = 0;

  // Peripheral side: record every strobe and apply writes to the register file.
  always @(negedge clk) begin
    if (bus.reg_we) begin
      weLog.push_back({bus.reg_addr, bus.reg_wdata});
      regFile[bus.reg_addr] = bus.reg_wdata;
    end
    if (bus.reg_rd) rdLog.push_back(bus.reg_addr);
    if (bus.sda_oe) oeCycles++;
    if (bus.busy) busyCycles++;
  end

  logic [7:0]  refMem [256] = '{default: 8'h00};
  logic [7:0]  ptrModel = 8'h00;
  logic [7:0]  txData [$];
  logic [7:0]  rxData [$];
  logic [15:0] expWe [$];

  int assertCount = 0;
  int failCount   = 0;

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic busStart();
    sdaDrv = 1'b0; waitClk(Q);
    sclDrv = 1'b0; waitClk(Q);
  endtask

  task automatic busRepStart();
    sdaDrv = 1'b1; waitClk(Q);
    sclDrv = 1'b1; waitClk(Q);
    sdaDrv = 1'b0; waitClk(Q);
    sclDrv = 1'b0; waitClk(Q);
  endtask

  task automatic busStop();
    sdaDrv = 1'b0; waitClk(Q);
    sclDrv = 1'b1; waitClk(Q);
    sdaDrv = 1'b1; waitClk(Q);
  endtask

  task automatic sendBits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      sdaDrv = d[7-i]; waitClk(Q);
      sclDrv = 1'b1;   waitClk(2*Q);
      sclDrv = 1'b0;   waitClk(Q);
    end
  endtask

  task automatic ackClock(output logic acked);
    sdaDrv = 1'b1; waitClk(Q);
    sclDrv = 1'b1; waitClk(Q);
    acked = ~bus.sda_i; waitClk(Q);
    sclDrv = 1'b0; waitClk(Q);
  endtask

  task automatic writeByte(input logic [7:0] d, output logic acked);
    sendBits(d, 8);
    ackClock(acked);
  endtask

  task automatic readByte(input logic nack, output logic [7:0] d);
    sdaDrv = 1'b1;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      waitClk(Q);
      sclDrv = 1'b1; waitClk(Q);
      d = {d[6:0], bus.sda_i}; waitClk(Q);
      sclDrv = 1'b0;
    end
    waitClk(4);
    sdaDrv = nack; waitClk(Q-4);
    sclDrv = 1'b1; waitClk(2*Q);
    sclDrv = 1'b0; waitClk(4);
    sdaDrv = 1'b1;
  endtask

  task automatic doWrite(input logic [7:0] addrByte, input logic [7:0] ptr, output int acks);
    logic a;
    acks = 0;
    busStart();
    writeByte(addrByte, a); acks += int'(a);
    writeByte(ptr, a);      acks += int'(a);
    foreach (txData[i]) begin
      writeByte(txData[i], a); acks += int'(a);
    end
    busStop();
  endtask

  // Leaves the bus open after the last byte so the caller can inspect state before STOP.
  task automatic doRead(input logic [7:0] ptr, input int n, output int acks);
    logic a;
    logic [7:0] d;
    acks = 0;
    rxData.delete();
    busStart();
    writeByte(8'h70, a); acks += int'(a);
    writeByte(ptr, a);   acks += int'(a);
    busRepStart();
    writeByte(8'h71, a); acks += int'(a);
    for (int i = 0; i < n; i++) begin
      readByte(i == n-1, d);
      rxData.push_back(d);
    end
  endtask

  task automatic modelWrite(input logic [7:0] p);
    expWe.delete();
    foreach (txData[i]) begin
      refMem[p] = txData[i];
      expWe.push_back({p, txData[i]});
      p = p + 8'd1;
    end
    ptrModel = p;
  endtask

  task automatic test_reset();
    reset = 1'b1; waitClk(5);
    assertCount++;
    if (bus.sda_oe !== 1'b0 || bus.reg_we !== 1'b0 || bus.reg_rd !== 1'b0 || bus.busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got oe=%0b we=%0b rd=%0b busy=%0b required all 0", bus.sda_oe, bus.reg_we, bus.reg_rd, bus.busy);
    end
    reset = 1'b0; waitClk(10);
    assertCount++;
    if (bus.i2c_state !== 4'(IDLE) || bus.reg_addr !== 8'h00 || bus.reg_wdata !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL reset_state: got state=%0d addr=%h wdata=%h required 0/00/00", bus.i2c_state, bus.reg_addr, bus.reg_wdata);
    end
  endtask

  task automatic test_write_burst();
    int acks;
    int base = weLog.size();
    txData = '{8'hAA, 8'h55};
    modelWrite(8'h25);
    doWrite(8'h70, 8'h25, acks);
    assertCount++;
    if (acks !== 4) begin failCount++; $display("[TB] FAIL wr_acks: got %0d required 4", acks); end
    assertCount++;
    if (weLog.size() - base !== expWe.size()) begin
      failCount++; $display("[TB] FAIL wr_count: got %0d required %0d", weLog.size() - base, expWe.size());
    end
    foreach (expWe[i]) begin
      logic [15:0] got = (base + i < weLog.size()) ? weLog[base+i] : 16'h0000;
      assertCount++;
      if (got !== expWe[i]) begin failCount++; $display("[TB] FAIL wr_entry%0d: got %h required %h", i, got, expWe[i]); end
    end
    assertCount++;
    if (bus.reg_addr !== ptrModel || bus.busy !== 1'b0) begin
      failCount++; $display("[TB] FAIL wr_final: got addr=%h busy=%0b required %h/0", bus.reg_addr, bus.busy, ptrModel);
    end
  endtask

  task automatic test_read_burst();
    int acks;
    int rbase;
    txData = '{8'hC3, 8'h3C};
    modelWrite(8'h10);
    doWrite(8'h70, 8'h10, acks);
    rbase = rdLog.size();
    doRead(8'h10, 2, acks);
    assertCount++;
    if (acks !== 3) begin failCount++; $display("[TB] FAIL rd_acks: got %0d required 3", acks); end
    assertCount++;
    if (bus.i2c_state !== 4'(WAIT_P)) begin
      failCount++; $display("[TB] FAIL rd_wait_p: got state=%0d required %0d", bus.i2c_state, 4'(WAIT_P));
    end
    busStop();
    assertCount++;
    if (bus.i2c_state !== 4'(IDLE) || bus.busy !== 1'b0) begin
      failCount++; $display("[TB] FAIL rd_idle: got state=%0d busy=%0b required 0/0", bus.i2c_state, bus.busy);
    end
    for (int i = 0; i < 2; i++) begin
      logic [7:0] exp = refMem[8'h10 + 8'(i)];
      logic [7:0] addr = (rbase + i < rdLog.size()) ? rdLog[rbase+i] : 8'hEE;
      assertCount++;
      if (rxData[i] !== exp) begin failCount++; $display("[TB] FAIL rd_data%0d: got %h required %h", i, rxData[i], exp); end
      assertCount++;
      if (addr !== 8'h10 + 8'(i)) begin failCount++; $display("[TB] FAIL rd_addr%0d: got %h required %h", i, addr, 8'h10 + 8'(i)); end
    end
    ptrModel = 8'h12;
    assertCount++;
    if (rdLog.size() - rbase !== 2 || bus.reg_addr !== ptrModel) begin
      failCount++; $display("[TB] FAIL rd_final: got rdcount=%0d addr=%h required 2/%h", rdLog.size() - rbase, bus.reg_addr, ptrModel);
    end
  endtask

  task automatic test_mismatch();
    int acks;
    int base  = weLog.size();
    int oe0   = oeCycles;
    txData = '{8'hAA};
    doWrite(8'h72, 8'h25, acks);
    assertCount++;
    if (acks !== 0 || oeCycles !== oe0) begin
      failCount++; $display("[TB] FAIL mm_ack: got acks=%0d oecycles=%0d required 0/0", acks, oeCycles - oe0);
    end
    assertCount++;
    if (weLog.size() !== base || bus.reg_addr !== ptrModel) begin
      failCount++; $display("[TB] FAIL mm_nowrite: got writes=%0d addr=%h required 0/%h", weLog.size() - base, bus.reg_addr, ptrModel);
    end
  endtask

  task automatic runWriteCase(input logic [7:0] p, input string name);
    int acks;
    int base = weLog.size();
    modelWrite(p);
    doWrite(8'h70, p, acks);
    assertCount++;
    if (acks !== txData.size() + 2 || weLog.size() - base !== expWe.size()) begin
      failCount++; $display("[TB] FAIL %s_count: got acks=%0d writes=%0d required %0d/%0d", name, acks, weLog.size() - base, txData.size() + 2, expWe.size());
    end
    foreach (expWe[i]) begin
      logic [15:0] got = (base + i < weLog.size()) ? weLog[base+i] : 16'h0000;
      assertCount++;
      if (got !== expWe[i]) begin failCount++; $display("[TB] FAIL %s_entry%0d: got %h required %h", name, i, got, expWe[i]); end
    end
    assertCount++;
    if (bus.reg_addr !== ptrModel) begin failCount++; $display("[TB] FAIL %s_ptr: got %h required %h", name, bus.reg_addr, ptrModel); end
  endtask

  task automatic test_wrap();
    txData = '{8'h01, 8'h02};
    runWriteCase(8'hFF, "wrap");
  endtask

  task automatic test_random();
    int acks;
    int rbase;
    int n;
    logic [7:0] p0 = 8'($urandom);
    for (int t = 0; t < 2; t++) begin
      txData.delete();
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) txData.push_back(8'($urandom));
      runWriteCase((t == 0) ? p0 : 8'($urandom), "rand_wr");
    end
    rbase = rdLog.size();
    doRead(p0, 3, acks);
    busStop();
    assertCount++;
    if (acks !== 3 || rdLog.size() - rbase !== 3) begin
      failCount++; $display("[TB] FAIL rand_rd_count: got acks=%0d reads=%0d required 3/3", acks, rdLog.size() - rbase);
    end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] exp = refMem[p0 + 8'(i)];
      assertCount++;
      if (rxData[i] !== exp) begin failCount++; $display("[TB] FAIL rand_rd_data%0d: got %h required %h", i, rxData[i], exp); end
    end
    ptrModel = p0 + 8'd3;
    assertCount++;
    if (bus.reg_addr !== ptrModel) begin failCount++; $display("[TB] FAIL rand_rd_ptr: got %h required %h", bus.reg_addr, ptrModel); end
  endtask

  task automatic test_glitch();
    int base  = weLog.size();
    int busy0 = busyCycles;
    for (int i = 0; i < 12; i++) begin
      waitClk($urandom_range(3, 12));
      sclDrv = 1'b0; waitClk(1);
      sclDrv = 1'b1;
    end
    waitClk(10);
    assertCount++;
    if (busyCycles !== busy0 || bus.i2c_state !== 4'(IDLE) || weLog.size() !== base) begin
      failCount++; $display("[TB] FAIL glitch: got busycycles=%0d state=%0d writes=%0d required 0/0/0", busyCycles - busy0, bus.i2c_state, weLog.size() - base);
    end
  endtask

  task automatic test_abort();
    logic a;
    int base;
    busStart();
    writeByte(8'h70, a);
    writeByte(8'h40, a);
    base = weLog.size();
    sendBits(8'hA5, 4);
    busRepStart();
    waitClk(4);
    assertCount++;
    if (bus.i2c_state !== 4'(ADDR) || bus.busy !== 1'b1 || weLog.size() !== base) begin
      failCount++; $display("[TB] FAIL abort_sr: got state=%0d busy=%0b writes=%0d required %0d/1/0", bus.i2c_state, bus.busy, weLog.size() - base, 4'(ADDR));
    end
    sendBits(8'h70, 8);
    sdaDrv = 1'b1; waitClk(Q);
    sclDrv = 1'b1; waitClk(Q/2);
    assertCount++;
    if (bus.sda_oe !== 1'b1) begin failCount++; $display("[TB] FAIL abort_acking: got oe=%0b required 1", bus.sda_oe); end
    #5 reset = 1'b1;
    #1;
    assertCount++;
    if (bus.sda_oe !== 1'b0) begin failCount++; $display("[TB] FAIL abort_async_release: got oe=%0b required 0", bus.sda_oe); end
    assertCount++;
    if (bus.reg_addr !== 8'h00 || bus.reg_wdata !== 8'h00 || bus.reg_we !== 1'b0 || bus.reg_rd !== 1'b0
        || bus.busy !== 1'b0 || bus.i2c_state !== 4'(IDLE)) begin
      failCount++;
      $display("[TB] FAIL abort_reset_outputs: got addr=%h wdata=%h we=%0b rd=%0b busy=%0b state=%0d required all 0",
               bus.reg_addr, bus.reg_wdata, bus.reg_we, bus.reg_rd, bus.busy, bus.i2c_state);
    end
    waitClk(5);
    reset = 1'b0;
    ptrModel = 8'h00;
    waitClk(10);
  endtask

  initial begin
    $display("[TB] i2c_target bench start");
    test_reset();
    test_write_burst();
    test_read_burst();
    test_mismatch();
    test_wrap();
    test_random();
    test_glitch();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
